// File: rtl/bank_conflict_scheduler_pkg.sv
// Shared sizing for the bank conflict scheduler: butterfly lane count and
// bank/lane index width, plus the scheduler FSM encoding.
package bank_conflict_scheduler_pkg;

  localparam int P    = 4;
  localparam int MAP  = 3;
  localparam int CNTW = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_t;

endpackage

// File: rtl/bank_conflict_scheduler_grant.sv
// Combinational grant selection: lowest pending lane wins each bank, and the
// winning set is also presented inverted as bank -> lane with a bank enable.
module conflict_grant_comb #(
  parameter int N_LANES = 8,
  parameter int MAPW    = 3
) (
  input  logic [N_LANES-1:0]      pending,
  input  logic [N_LANES*MAPW-1:0] bi_bus,
  output logic [N_LANES-1:0]      gnt_mask,
  output logic [N_LANES-1:0]      bank_en,
  output logic [N_LANES*MAPW-1:0] bank_lane_bus
);

  always_comb begin
    gnt_mask      = '0;
    bank_en       = '0;
    bank_lane_bus = '0;
    for (int i = 0; i < N_LANES; i++) begin
      gnt_mask[i] = pending[i];
      // A lower pending lane on the same bank blocks this one for now.
      for (int j = 0; j < i; j++) begin
        if (pending[j] && (bi_bus[j*MAPW +: MAPW] == bi_bus[i*MAPW +: MAPW]))
          gnt_mask[i] = 1'b0;
      end
    end
    for (int i = 0; i < N_LANES; i++) begin
      if (gnt_mask[i]) begin
        bank_en[bi_bus[i*MAPW +: MAPW]]                       = 1'b1;
        bank_lane_bus[int'(bi_bus[i*MAPW +: MAPW])*MAPW +: MAPW] = MAPW'(i);
      end
    end
  end

endmodule

// File: rtl/bank_conflict_scheduler.sv
// Splits one batch of per-lane bank requests into conflict-free issue cycles
// and tracks how many extra cycles bank conflicts have cost.
module bank_conflict_scheduler
  import bank_conflict_scheduler_pkg::*;
#(
  parameter int N_LANES = 2*P,
  parameter int MAPW    = MAP,
  parameter int CNTW    = bank_conflict_scheduler_pkg::CNTW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [N_LANES-1:0]      req_mask,
  input  logic [N_LANES*MAPW-1:0] req_bi_bus,
  output logic                    gnt_valid,
  input  logic                    gnt_ready,
  output logic [N_LANES-1:0]      gnt_mask,
  output logic [N_LANES*MAPW-1:0] gnt_bi_bus,
  output logic [N_LANES*MAPW-1:0] bank_lane_bus,
  output logic [N_LANES-1:0]      bank_en,
  output logic                    batch_done,
  output logic [CNTW-1:0]         conflict_cnt
);

  sched_state_t              state;
  logic [N_LANES-1:0]        pending;
  logic [N_LANES-1:0]        pending_next;
  logic [N_LANES*MAPW-1:0]   bi_q;

  conflict_grant_comb #(
    .N_LANES (N_LANES),
    .MAPW    (MAPW)
  ) u_grant (
    .pending       (pending),
    .bi_bus        (bi_q),
    .gnt_mask      (gnt_mask),
    .bank_en       (bank_en),
    .bank_lane_bus (bank_lane_bus)
  );

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its payload stay stable until that edge.
  assign req_ready    = (state == IDLE);
  assign gnt_valid    = (state == ISSUE);
  assign gnt_bi_bus   = bi_q;
  assign pending_next = pending & ~gnt_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pending      <= '0;
      bi_q         <= '0;
      conflict_cnt <= '0;
      batch_done   <= 1'b0;
    end else begin
      batch_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            bi_q    <= req_bi_bus;
            pending <= req_mask;
            if (req_mask != '0) state      <= ISSUE;
            else                batch_done <= 1'b1;
          end
        end
        ISSUE: begin
          if (gnt_ready) begin
            pending <= pending_next;
            if (pending_next == '0) begin
              state      <= IDLE;
              batch_done <= 1'b1;
            end else if (conflict_cnt != '1) begin
              conflict_cnt <= conflict_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
